// File: rtl/spi_flash_pkg.sv
// Shared constants and state encoding for the SPI configuration-flash reader.
package spi_flash_pkg;

  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam int unsigned ADDR_BITS = 24;
  // Opcode plus address, shifted out as one 32-bit header.
  localparam int unsigned HDR_BITS  = 8 + ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CMD,
    ADDR,
    DATA,
    CS_HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/spi_flash_reader_sck_gen.sv
// SPI mode-0 clock generator: CLK_DIV clk cycles per SCK phase.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   en_i      : run the clock; when low SCK is forced low and the phase restarts
//   hold_i    : stretch the low phase (blocks the next rising edge)
//   sck_o     : registered SCK level
//   rise_c_o  : combinational, high in the cycle whose clk edge drives SCK 0->1
//   fall_c_o  : combinational, high in the cycle whose clk edge drives SCK 1->0
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic hold_i,
  output logic sck_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  localparam int unsigned CNT_W = 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             last_c;

  assign last_c   = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign rise_c_o = en_i && !sck_q && last_c && !hold_i;
  assign fall_c_o = en_i && sck_q && last_c;
  assign sck_o    = sck_q;

  // Phase counter; saturates at the end of the low phase while held.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (rise_c_o || fall_c_o) begin
      cnt_d = '0;
      sck_d = !sck_q;
    end else if (!last_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI initiator issuing READ (0x03) + 24-bit address to the configuration
// flash, then streaming len bytes out over a valid/ready interface.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   start, addr, len    : request (sampled in IDLE), byte address, byte count
//   busy, done          : transaction in flight / one-cycle completion pulse
//   rd_data, rd_valid,
//   rd_ready            : received byte stream, held until accepted
//   flash_cs/sck/mosi,
//   flash_miso          : flash pins (CS active-low, SPI mode 0)
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 flash_cs,
  output logic                 flash_sck,
  output logic                 flash_mosi,
  input  logic                 flash_miso
);

  localparam int unsigned CNT_W = 9;

  state_e              state_q;
  logic [HDR_BITS-1:0] shift_q;
  logic [LEN_W-1:0]    rem_q;
  logic [5:0]          bit_cnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          rx_q;
  logic                pend_q;
  logic                cs_q, busy_q, done_q, rd_valid_q;
  logic [7:0]          rd_data_q;

  logic sck_en_c, sck_hold_c, sck_rise_c, sck_fall_c;

  assign sck_en_c   = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  // Block the 8th rising edge of a byte until the output register is free.
  assign sck_hold_c = (state_q == DATA) && (bit_cnt_q[2:0] == 3'd7) &&
                      (rd_valid_q || pend_q);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst      (rst),
    .en_i     (sck_en_c),
    .hold_i   (sck_hold_c),
    .sck_o    (flash_sck),
    .rise_c_o (sck_rise_c),
    .fall_c_o (sck_fall_c)
  );

  // MOSI is the header MSB; the header drains to zero, so MOSI is 0 in DATA.
  assign flash_mosi = shift_q[HDR_BITS-1];
  assign flash_cs   = cs_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      rem_q      <= '0;
      bit_cnt_q  <= '0;
      cnt_q      <= '0;
      rx_q       <= '0;
      pend_q     <= 1'b0;
      cs_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      pend_q <= 1'b0;

      // Output byte register: load one clk after the byte's last sample.
      if (pend_q) begin
        rd_data_q  <= rx_q;
        rd_valid_q <= 1'b1;
      end else if (rd_valid_q && rd_ready) begin
        rd_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            rem_q  <= len;
            if (len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CS_SETUP;
              cs_q    <= 1'b0;
              shift_q <= {CMD_READ, addr};
              cnt_q   <= '0;
            end
          end
        end

        CS_SETUP: begin
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            state_q   <= CMD;
            bit_cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        CMD, ADDR: begin
          if (sck_fall_c) begin
            shift_q   <= shift_q << 1;
            bit_cnt_q <= bit_cnt_q + 6'd1;
            if (state_q == CMD && bit_cnt_q == 6'd7) begin
              state_q <= ADDR;
            end
            if (state_q == ADDR && bit_cnt_q == 6'd31) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end
          end
        end

        DATA: begin
          if (sck_rise_c) begin
            rx_q      <= {rx_q[6:0], flash_miso};
            bit_cnt_q <= bit_cnt_q + 6'd1;
            if (bit_cnt_q[2:0] == 3'd7) begin
              pend_q <= 1'b1;
              rem_q  <= rem_q - LEN_W'(1);
            end
          end
          // Leave on the falling edge that follows the final byte's 8th rise.
          if (sck_fall_c && bit_cnt_q[2:0] == 3'd0 && rem_q == '0) begin
            state_q <= CS_HOLD;
            cnt_q   <= '0;
          end
        end

        CS_HOLD: begin
          // First CLK_DIV cycles CS stays low, next CLK_DIV cycles deselected.
          if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
            cs_q <= 1'b1;
          end
          if (cnt_q == CNT_W'(2 * CLK_DIV - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
